// File: rtl/cursor_position_counter_if.sv
// Command/position bundle between the direction logic and the cursor counter.
interface cursor_position_counter_if #(
  parameter int unsigned POS_W = 4
);
  logic [3:0]       dir_cmd;
  logic             step_req;
  logic             hold;
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] col;
  logic             moved;
  logic             wrapped;

  // Command source: drives direction/step/hold, observes cursor
  modport master (
    output dir_cmd, step_req, hold,
    input  row, col, moved, wrapped
  );

  // Cursor counter: consumes commands, drives position and pulses
  modport slave (
    input  dir_cmd, step_req, hold,
    output row, col, moved, wrapped
  );
endinterface

// File: rtl/cursor_position_counter.sv
// Sudoku cursor row/column counter with single-step and typematic auto-repeat.
module cursor_position_counter #(
  parameter int unsigned GRID_SIZE     = 9,
  parameter int unsigned POS_W         = 4,
  parameter int unsigned REPEAT_DELAY  = 25000,
  parameter int unsigned REPEAT_PERIOD = 10000,
  parameter int unsigned TMR_W         = 16
) (
  input logic                       clk,
  input logic                       rst,
  cursor_position_counter_if.slave  bus
);

  localparam logic [POS_W-1:0] POS_MAX      = POS_W'(GRID_SIZE - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST   = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST  = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             step_prev;
  logic [POS_W-1:0] cur_row;
  logic [POS_W-1:0] cur_col;
  logic             move_pend;
  logic             wrap_pend;
  logic             moved;
  logic             wrapped;

  logic             move_now;
  logic [POS_W-1:0] next_row;
  logic [POS_W-1:0] next_col;
  logic             row_wrap;
  logic             col_wrap;

  // Decide whether this cycle performs a move
  always_comb begin
    move_now = 1'b0;
    if (!bus.hold) begin
      unique case (state)
        IDLE:    move_now = bus.step_req && !step_prev;
        DELAY:   move_now = bus.step_req && (timer == DELAY_LAST);
        REPEAT:  move_now = bus.step_req && (timer == PERIOD_LAST);
        default: move_now = 1'b0;
      endcase
    end
  end

  // Next column with wrap at the board edges
  always_comb begin
    next_col = cur_col;
    col_wrap = 1'b0;
    if (bus.dir_cmd[0]) begin
      if (bus.dir_cmd[1]) begin
        if (cur_col == POS_MAX) begin
          next_col = '0;
          col_wrap = 1'b1;
        end else begin
          next_col = cur_col + POS_W'(1);
        end
      end else begin
        if (cur_col == '0) begin
          next_col = POS_MAX;
          col_wrap = 1'b1;
        end else begin
          next_col = cur_col - POS_W'(1);
        end
      end
    end
  end

  // Next row with wrap at the board edges
  always_comb begin
    next_row = cur_row;
    row_wrap = 1'b0;
    if (bus.dir_cmd[2]) begin
      if (bus.dir_cmd[3]) begin
        if (cur_row == POS_MAX) begin
          next_row = '0;
          row_wrap = 1'b1;
        end else begin
          next_row = cur_row + POS_W'(1);
        end
      end else begin
        if (cur_row == '0) begin
          next_row = POS_MAX;
          row_wrap = 1'b1;
        end else begin
          next_row = cur_row - POS_W'(1);
        end
      end
    end
  end

  // Repeat FSM, position registers and delayed move/wrap pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      step_prev <= 1'b0;
      cur_row   <= '0;
      cur_col   <= '0;
      move_pend <= 1'b0;
      wrap_pend <= 1'b0;
      moved     <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      step_prev <= bus.step_req;
      moved     <= move_pend;
      wrapped   <= wrap_pend;
      move_pend <= move_now;
      wrap_pend <= move_now && (row_wrap || col_wrap);

      if (move_now) begin
        cur_row <= next_row;
        cur_col <= next_col;
      end

      // Hold freezes state and timer entirely
      if (!bus.hold) begin
        unique case (state)
          IDLE: begin
            if (move_now) begin
              timer <= '0;
              state <= DELAY;
            end
          end
          DELAY: begin
            if (!bus.step_req) begin
              state <= IDLE;
            end else if (move_now) begin
              timer <= '0;
              state <= REPEAT;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          REPEAT: begin
            if (!bus.step_req) begin
              state <= IDLE;
            end else if (move_now) begin
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.row     = cur_row;
  assign bus.col     = cur_col;
  assign bus.moved   = moved;
  assign bus.wrapped = wrapped;

endmodule

// File: tb/tb_cursor_position_counter.sv
// Directed bench for cursor_position_counter (short repeat timing).
module tb_cursor_position_counter;

  localparam int unsigned POS_W = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cursor_position_counter_if #(.POS_W(POS_W)) bus ();

  cursor_position_counter #(
    .GRID_SIZE     (9),
    .POS_W         (POS_W),
    .REPEAT_DELAY  (4),
    .REPEAT_PERIOD (2),
    .TMR_W         (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dir;
    int         row;
    int         col;
    int         wrap;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.step_req = 1'b0;
    bus.hold     = 1'b0;
    bus.dir_cmd  = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int cnt_le(input int mv[8], input int k);
    int n = 0;
    for (int i = 0; i < 8; i++) if (mv[i] >= 0 && mv[i] <= k) n++;
    return n;
  endfunction

  function automatic int is_in(input int mv[8], input int k);
    for (int i = 0; i < 8; i++) if (mv[i] >= 0 && mv[i] == k) return 1;
    return 0;
  endfunction

  // Hold step_req for step_hi cycles (hold high over [h_lo,h_hi]); expected moves at cycles in mv
  task automatic run_seq(input string name, input logic [3:0] dir, input int use_row,
                         input int step_hi, input int h_lo, input int h_hi,
                         input int ncyc, input int mv[8]);
    bus.dir_cmd = dir;
    for (int k = 0; k < ncyc; k++) begin
      bus.step_req = (k < step_hi);
      bus.hold     = (k >= h_lo && k <= h_hi);
      @(negedge clk);
      if (use_row != 0) chk({name, "_row"}, int'(bus.row), cnt_le(mv, k));
      else              chk({name, "_col"}, int'(bus.col), cnt_le(mv, k));
      chk({name, "_moved"}, int'(bus.moved), is_in(mv, k - 1));
      chk({name, "_wrapped"}, int'(bus.wrapped), 0);
    end
    bus.step_req = 1'b0;
    bus.hold     = 1'b0;
  endtask

  initial begin
    int mv[8];
    errors = 0;
    checks = 0;

    vecs[0]  = '{4'b0011, 0, 1, 0};
    vecs[1]  = '{4'b0001, 0, 0, 0};
    vecs[2]  = '{4'b0001, 0, 8, 1};
    vecs[3]  = '{4'b0011, 0, 0, 1};
    vecs[4]  = '{4'b0100, 8, 0, 1};
    vecs[5]  = '{4'b0001, 8, 8, 1};
    vecs[6]  = '{4'b1111, 0, 0, 1};
    vecs[7]  = '{4'b0000, 0, 0, 0};
    vecs[8]  = '{4'b1100, 1, 0, 0};
    vecs[9]  = '{4'b0111, 0, 1, 0};
    vecs[10] = '{4'b1101, 1, 0, 0};
    vecs[11] = '{4'b0010, 1, 0, 0};

    do_reset();
    chk("reset_row", int'(bus.row), 0);
    chk("reset_col", int'(bus.col), 0);
    chk("reset_moved", int'(bus.moved), 0);
    chk("reset_wrapped", int'(bus.wrapped), 0);

    // Single-step table: one-cycle pulse per vector
    foreach (vecs[i]) begin
      bus.dir_cmd  = vecs[i].dir;
      bus.step_req = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_row", i), int'(bus.row), vecs[i].row);
      chk($sformatf("v%0d_col", i), int'(bus.col), vecs[i].col);
      chk($sformatf("v%0d_moved_early", i), int'(bus.moved), 0);
      bus.step_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_moved", i), int'(bus.moved), 1);
      chk($sformatf("v%0d_wrapped", i), int'(bus.wrapped), vecs[i].wrap);
      bus.dir_cmd = ~vecs[i].dir;
      @(negedge clk);
      chk($sformatf("v%0d_moved_end", i), int'(bus.moved), 0);
      chk($sformatf("v%0d_row_stable", i), int'(bus.row), vecs[i].row);
      chk($sformatf("v%0d_col_stable", i), int'(bus.col), vecs[i].col);
    end

    // Auto-repeat cadence: moves at 0,4,6,8,10 then release
    do_reset();
    mv = '{0, 4, 6, 8, 10, -1, -1, -1};
    run_seq("repeat", 4'b1100, 1, 12, 100, -1, 16, mv);

    // Rising edge while hold is high is ignored
    do_reset();
    mv = '{-1, -1, -1, -1, -1, -1, -1, -1};
    run_seq("hold_edge", 4'b0011, 0, 6, 0, 2, 8, mv);

    // Hold in REPEAT freezes timer; cadence resumes with remaining count
    do_reset();
    mv = '{0, 4, 9, 11, -1, -1, -1, -1};
    run_seq("hold_rpt", 4'b0011, 0, 13, 6, 8, 15, mv);

    // Reset during REPEAT with step_req high
    do_reset();
    bus.dir_cmd  = 4'b0011;
    bus.step_req = 1'b1;
    for (int k = 0; k < 7; k++) @(negedge clk);
    chk("rstrep_pre_col", int'(bus.col), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rstrep_col", int'(bus.col), 0);
    chk("rstrep_row", int'(bus.row), 0);
    chk("rstrep_moved", int'(bus.moved), 0);
    @(negedge clk);
    chk("rstrep_moved2", int'(bus.moved), 0);
    rst          = 1'b0;
    bus.step_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstrep_idle_col", int'(bus.col), 0);
      chk("rstrep_idle_moved", int'(bus.moved), 0);
    end
    bus.step_req = 1'b1;
    @(negedge clk);
    chk("rstrep_restart_col", int'(bus.col), 1);
    bus.step_req = 1'b0;
    @(negedge clk);
    chk("rstrep_restart_moved", int'(bus.moved), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
